// File: rtl/timer_contador_if.sv
// Keypad / magnetron / display bundle of the microwave cooking timer.
// master: keypad and magnetron side (drives inputs, reads the display).
// slave : the timer itself.
interface timer_contador_if;
    logic       clearn;       // keypad clear, active-low, level-sensitive
    logic       digit_valid;  // one-cycle strobe: digit holds a keypad digit
    logic [3:0] digit;        // BCD keypad digit 0-9
    logic       mag_on;       // magnetron running; enables countdown
    logic       startn;       // start button, active-low (quick start only)
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       timer_done;   // high while the time is 00:00

    modport master (
        output clearn, digit_valid, digit, mag_on, startn,
        input  min_tens, min_ones, sec_tens, sec_ones, timer_done
    );

    modport slave (
        input  clearn, digit_valid, digit, mag_on, startn,
        output min_tens, min_ones, sec_tens, sec_ones, timer_done
    );
endinterface

// File: rtl/timer_contador.sv
// Cooking-time countdown timer: holds a 4-digit BCD MM:SS value entered from
// the keypad, counts it down once per second while the magnetron runs, and
// flags timer_done at 00:00.
// Optional macro TIMER_QUICK_START_EN: a start-button press at 00:00 with the
// magnetron off loads 00:30.
module timer_contador #(
    parameter int CLK_HZ = 100  // clk cycles per second, >= 2
) (
    input logic              clk,
    input logic              rst,
    timer_contador_if.slave  bus
);

    localparam int              PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);

    if (CLK_HZ < 2) begin : g_bad_clk_hz
        $error("timer_contador: CLK_HZ must be >= 2");
    end

    logic [15:0]   count_q, count_d;  // {min_tens, min_ones, sec_tens, sec_ones}
    logic [PW-1:0] presc_q, presc_d;
    logic          count_zero;

    assign count_zero = (count_q == 16'h0000);

    // One-second BCD decrement with borrow through all four digits.
    // Never applied to 00:00, so the minutes-tens underflow cannot occur.
    function automatic logic [15:0] bcd_dec(input logic [15:0] c);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = c;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

`ifdef TIMER_QUICK_START_EN
    logic startn_q;
    logic start_fall;

    // Start-button history for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            startn_q <= 1'b1;
        end else begin
            startn_q <= bus.startn;
        end
    end

    assign start_fall = startn_q & ~bus.startn;
`else
    logic startn_unused;
    assign startn_unused = bus.startn;
`endif

    // Next-state: clear > quick start > digit entry > countdown.
    always_comb begin
        // NOTE: hold-by-default assignments first keep this block latch-free.
        count_d = count_q;
        presc_d = presc_q;
        if (!bus.clearn) begin
            count_d = 16'h0000;
            presc_d = '0;
        end
`ifdef TIMER_QUICK_START_EN
        else if (start_fall && !bus.mag_on && count_zero) begin
            count_d = 16'h0030;
            presc_d = '0;
        end
`endif
        else if (bus.digit_valid && !bus.mag_on && (bus.digit <= 4'd9)) begin
            count_d = {count_q[11:0], bus.digit};
            presc_d = '0;
        end else if (bus.mag_on && !count_zero) begin
            if (presc_q == PRESC_MAX) begin
                // Wrapping here also leaves the prescaler at 0 on reaching 00:00.
                presc_d = '0;
                count_d = bcd_dec(count_q);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Count and prescaler registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            count_q <= 16'h0000;
            presc_q <= '0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
        end
    end

    assign bus.min_tens   = count_q[15:12];
    assign bus.min_ones   = count_q[11:8];
    assign bus.sec_tens   = count_q[7:4];
    assign bus.sec_ones   = count_q[3:0];
    assign bus.timer_done = count_zero;

endmodule

// File: doc/timer_contador.md
Name: timer_contador

Overview:
- Cooking-time countdown timer for the microwave; the counterpart of the magnetron control block.
- Consumes the magnetron's mag_on and produces the timer_done that the control block samples.
- Holds a 4-digit BCD time MM:SS loaded from the keypad and decrements it once per second while mag_on is high.
- Drives the display digits and asserts timer_done when the time reaches 00:00.

Parameters:
- CLK_HZ, 100: clk cycles per second; the prescaler period. Must be >= 2.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- clearn  input  1  keypad clear, active-low, level-sensitive
- digit_valid  input  1  one-cycle strobe: digit holds a keypad digit
- digit  input  4  BCD keypad digit 0-9
- mag_on  input  1  magnetron running; enables countdown
- startn  input  1  start button, active-low; used only by the optional feature
- min_tens  output  4  BCD minutes tens
- min_ones  output  4  BCD minutes ones
- sec_tens  output  4  BCD seconds tens
- sec_ones  output  4  BCD seconds ones
- timer_done  output  1  high when the time is 00:00

Behaviour:
- Registers:
  - count = {min_tens, min_ones, sec_tens, sec_ones}, 16 bits.
  - prescaler, range 0..CLK_HZ-1, width $clog2(CLK_HZ).
- Reset: rst=1 at a clk edge sets count=0000 and prescaler=0. As a result timer_done=1 during and after reset.
- timer_done: combinational decode of the registered count (count==0000). No added latency.
- Priority per clock edge, highest first: rst, then clear, then digit entry, then countdown.
- Clear: clearn=0 sets count=0000 and prescaler=0. This holds every cycle clearn is low, regardless of mag_on.
- Digit entry:
  - Accepted only when digit_valid=1, mag_on=0 and digit<=9.
  - Shift left one digit: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit. The old min_tens is discarded.
  - Also sets prescaler=0.
  - digit>9, or any entry while mag_on=1, is ignored with no state change.
- Seconds digits above 5 are legal after entry (e.g. 00:90). They count down naturally.
- Countdown:
  - While mag_on=1 and count!=0000, the prescaler increments each cycle.
  - When prescaler==CLK_HZ-1 it wraps to 0 and count decrements by one second in the same edge.
  - The first decrement therefore occurs exactly CLK_HZ cycles after mag_on is first sampled high.
- BCD decrement rules:
  - sec_ones>0: sec_ones-1.
  - sec_ones=0, sec_tens>0: sec_tens-1, sec_ones=9.
  - sec=00: seconds become 59 and minutes decrement with the same BCD borrow (min_ones 0 -> 9, min_tens-1).
  - Example sequence: 10:00 -> 09:59 -> ... -> 00:00.
- Zero handling:
  - At count==0000 no decrement occurs and the prescaler holds at 0, even if mag_on stays high.
  - The transition into 0000 sets the prescaler to 0.
- Pause: mag_on falling mid-second freezes the prescaler at its current value; it resumes from there when mag_on returns high. Door-open pauses therefore do not lose a partial second.
- The block contains no FSM beyond the prescaler and count registers. Legal count range is 00:00..99:99.

Optional Feature:
- Macro: TIMER_QUICK_START_EN.
- Defined:
  - startn is registered once (reset value 1). A falling edge is detected when the registered value is 1 and the current startn is 0.
  - A falling edge with mag_on=0 and count==0000 loads count=00:30 and prescaler=0 on that edge.
  - Lower priority than rst and clear; higher than digit entry.
  - Not active when count!=0000 or mag_on=1.
- Undefined: startn is unused and no edge register is built; behaviour is otherwise identical.

Test Plan (CLK_HZ=4):
- Reset: rst=1 for 2 cycles -> all digits 0, timer_done=1.
- Keypad entry: with mag_on=0, strobe digits 1,2,3,4 -> count 12:34, timer_done=0. Then strobe digit 0xA -> count unchanged. Then strobe 5 -> 23:45.
- Countdown: load 01:00, then hold mag_on=1.
  - First decrement to 00:59 exactly 4 cycles after mag_on is sampled high.
  - Reaches 00:00 after 240 cycles; timer_done=1 and count holds.
- Pause: load 00:02, mag_on=1 for 6 cycles (-> 00:01, prescaler=2), mag_on=0 for 10 cycles, mag_on=1 again -> 00:00 after 2 more cycles.
- Clear and lockout: during countdown at 05:00, pulse digit_valid with digit=7 while mag_on=1 -> ignored. Drive clearn=0 together with digit_valid -> count 0000, timer_done=1.
- Quick start (macro defined): count 0000, mag_on=0, drive startn 1->0 -> count 00:30 next edge. Repeat the press with count 00:30 -> no change.
